riscv_multicycle_core: RTL and testbench



---
 rtl/riscv_mc_pkg.sv | 48 ++++
 rtl/riscv_mc_alu.sv | 31 +++
 rtl/riscv_multicycle_core.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_riscv_multicycle_core.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared constants and types for the multi-cycle RV32 core.
// Opcodes, funct fields, FSM state codes, ALU ops and immediate formats.
package riscv_mc_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WB     = 3'd4;
    localparam state_t S_TRAP   = 3'd5;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_type_e;

endpackage

// File: rtl/riscv_mc_alu.sv
// Shared ALU: add/sub/and/or/slt with result-zero and signed less-than flags.
module riscv_mc_alu
    import riscv_mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  alu_op_e         op_i,
    output logic [XLEN-1:0] y_o,
    output logic            zero_o,
    output logic            lt_o
);

    assign lt_o = $signed(a_i) < $signed(b_i);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {{(XLEN-1){1'b0}}, lt_o};
            default: y_o = '0;
        endcase
    end

    assign zero_o = (y_o == '0);

endmodule

// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32 subset core with one ALU and one unified memory port.
// Define PERF_CNT_EN to add 64-bit cycle_cnt / instret_cnt outputs.
module riscv_multicycle_core
    import riscv_mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            areset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic            instr_retired,
    output logic            trap,
    output logic [XLEN-1:0] pc_out
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] oldpc_q, oldpc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mdr_q, mdr_d;
    logic            trap_q, trap_d;
    logic [XLEN-1:0] rf_q [NREGS];
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd, rs1, rs2;
    assign opc = ir_q[6:0];
    assign rd  = ir_q[11:7];
    assign f3  = ir_q[14:12];
    assign rs1 = ir_q[19:15];
    assign rs2 = ir_q[24:20];
    assign f7  = ir_q[31:25];

    logic      legal, use_imm, is_lw, is_sw, is_br, is_blt, is_jal;
    logic      use_rs1, use_rs2, use_rd;
    alu_op_e   ex_op;
    imm_type_e imm_type;

    always_comb begin
        legal    = 1'b0;
        use_imm  = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_br    = 1'b0;
        is_blt   = 1'b0;
        is_jal   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        ex_op    = ALU_ADD;
        imm_type = IMM_NONE;
        unique case (opc)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                legal   = (f7 == F7_BASE &&
                           (f3 == F3_ADD || f3 == F3_SLT ||
                            f3 == F3_OR || f3 == F3_AND)) ||
                          (f7 == F7_SUB && f3 == F3_ADD);
                unique case (f3)
                    F3_SLT:  ex_op = ALU_SLT;
                    F3_OR:   ex_op = ALU_OR;
                    F3_AND:  ex_op = ALU_AND;
                    default: ex_op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                endcase
            end
            OPC_OP_IMM: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                use_imm  = 1'b1;
                imm_type = IMM_I;
                legal    = (f3 == F3_ADD || f3 == F3_SLT ||
                            f3 == F3_OR || f3 == F3_AND);
                unique case (f3)
                    F3_SLT:  ex_op = ALU_SLT;
                    F3_OR:   ex_op = ALU_OR;
                    F3_AND:  ex_op = ALU_AND;
                    default: ex_op = ALU_ADD;
                endcase
            end
            OPC_LOAD: begin
                use_rs1  = 1'b1;
                use_rd   = 1'b1;
                use_imm  = 1'b1;
                is_lw    = 1'b1;
                imm_type = IMM_I;
                legal    = (f3 == F3_LW);
            end
            OPC_STORE: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                use_imm  = 1'b1;
                is_sw    = 1'b1;
                imm_type = IMM_S;
                legal    = (f3 == F3_SW);
            end
            OPC_BRANCH: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                is_br    = 1'b1;
                is_blt   = (f3 == F3_BLT);
                ex_op    = ALU_SUB;
                imm_type = IMM_B;
                legal    = (f3 == F3_BEQ || f3 == F3_BLT);
            end
            OPC_JAL: begin
                use_rd   = 1'b1;
                is_jal   = 1'b1;
                imm_type = IMM_J;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if ((use_rs1 && int'(rs1) >= NREGS) ||
            (use_rs2 && int'(rs2) >= NREGS) ||
            (use_rd && int'(rd) >= NREGS))
            legal = 1'b0;
    end

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm32 = '0;
        unique case (imm_type)
            IMM_I: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            IMM_S: imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            IMM_B: imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7],
                            ir_q[30:25], ir_q[11:8], 1'b0};
            IMM_J: imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12],
                            ir_q[20], ir_q[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    // DECODE borrows the ALU to precompute OLDPC + imm as the jump target.
    logic [XLEN-1:0] alu_a, alu_b, alu_y;
    logic            alu_zero, alu_lt;
    alu_op_e         alu_op;

    always_comb begin
        alu_a  = a_q;
        alu_b  = use_imm ? imm_q : b_q;
        alu_op = ex_op;
        if (state_q == S_DECODE) begin
            alu_a  = oldpc_q;
            alu_b  = imm;
            alu_op = ALU_ADD;
        end
    end

    riscv_mc_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .a_i    (alu_a),
        .b_i    (alu_b),
        .op_i   (alu_op),
        .y_o    (alu_y),
        .zero_o (alu_zero),
        .lt_o   (alu_lt)
    );

    logic br_taken;
    assign br_taken = is_blt ? alu_lt : alu_zero;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        oldpc_d  = oldpc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        imm_d    = imm_q;
        tgt_d    = tgt_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        trap_d   = trap_q;
        rf_we    = 1'b0;
        rf_wdata = is_lw ? mdr_q : alu_q;
        unique case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    oldpc_d = pc_q;
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    trap_d  = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    a_d     = rf_q[rs1[IW-1:0]];
                    b_d     = rf_q[rs2[IW-1:0]];
                    imm_d   = imm;
                    tgt_d   = alu_y;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    if (br_taken)
                        pc_d = {tgt_q[XLEN-1:2], 2'b00};
                    state_d = S_FETCH;
                end else if (is_jal) begin
                    pc_d    = tgt_q;
                    alu_d   = pc_q;
                    state_d = S_WB;
                end else begin
                    alu_d   = alu_y;
                    state_d = (is_lw || is_sw) ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                rf_we   = (rd != 5'd0);
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            oldpc_q <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            tgt_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            trap_q  <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            oldpc_q <= oldpc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            tgt_q   <= tgt_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
            trap_q  <= trap_d;
            if (rf_we)
                rf_q[rd[IW-1:0]] <= rf_wdata;
        end
    end

    // Outputs are gated by areset so a reset drops a pending request at once.
    logic in_fetch, in_mem;
    assign in_fetch = !areset && state_q == S_FETCH;
    assign in_mem   = !areset && state_q == S_MEM;

    assign mem_req   = in_fetch || in_mem;
    assign mem_we    = in_mem && is_sw;
    assign mem_addr  = in_fetch ? {pc_q[XLEN-1:2], 2'b00} :
                       in_mem   ? {alu_q[XLEN-1:2], 2'b00} : '0;
    assign mem_wdata = (in_mem && is_sw) ? b_q : '0;

    assign instr_retired = !areset &&
                           ((state_q == S_EXEC && is_br) ||
                            (state_q == S_MEM && mem_ready && is_sw) ||
                            state_q == S_WB);
    assign trap   = trap_q;
    assign pc_out = pc_q;

`ifdef PERF_CNT_EN
    logic [63:0] cyc_q, ret_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if (state_q != S_TRAP)
                cyc_q <= cyc_q + 64'd1;
            if (instr_retired)
                ret_q <= ret_q + 64'd1;
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core with a wait-state memory model.
module tb_riscv_multicycle_core;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] OPI = 7'b0010011;

    logic        clk;
    logic        areset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        instr_retired;
    logic        trap;
    logic [31:0] pc_out;
`ifdef PERF_CNT_EN
    logic [63:0] cycle_cnt;
    logic [63:0] instret_cnt;
`endif

    riscv_multicycle_core #(
        .XLEN     (32),
        .NREGS    (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready),
        .instr_retired (instr_retired),
        .trap          (trap),
        .pc_out        (pc_out)
`ifdef PERF_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instret_cnt   (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          checks = 0;
    int          failures = 0;
    int          fetch_wait = 0;
    int          data_wait = 0;
    int          txn_idx = 0;
    int          wcnt = 0;
    int          req_cyc = 0;
    int          lat;
    int          r0;
    logic [31:0] fetch_addr;
    logic [31:0] st_addr;
    logic [31:0] st_data;

    // Memory responder: the first transaction of a step uses fetch_wait.
    always @(negedge clk) begin
        int w;
        mem_ready = 1'b0;
        if (mem_req) begin
            req_cyc++;
            w = (txn_idx == 0) ? fetch_wait : data_wait;
            if (wcnt >= w) begin
                mem_ready = 1'b1;
                if (mem_we) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    st_addr = mem_addr;
                    st_data = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr[9:2]];
                    if (txn_idx == 0)
                        fetch_addr = mem_addr;
                end
                wcnt = 0;
                txn_idx++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] epc, input int fw, input int dw,
                        input int elat, input string tag);
        int n;
        fetch_wait = fw;
        data_wait  = dw;
        txn_idx    = 0;
        fetch_addr = 32'hFFFF_FFFF;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while (!instr_retired && n < 40);
        chk(fetch_addr, epc, {tag, " pc"});
        chk(n, elat, {tag, " lat"});
    endtask

    function automatic logic [31:0] r_t(logic [6:0] f7, int rs2, int rs1,
                                        logic [2:0] f3, int rd);
        return {f7, rs2[4:0], rs1[4:0], f3, rd[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(int imm, int rs1, logic [2:0] f3,
                                        int rd, logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3, rd[4:0], op};
    endfunction

    function automatic logic [31:0] s_t(int imm, int rs2, int rs1);
        logic [11:0] m;
        m = imm[11:0];
        return {m[11:5], rs2[4:0], rs1[4:0], 3'b010, m[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] b_t(int imm, int rs2, int rs1,
                                        logic [2:0] f3);
        logic [12:0] m;
        m = imm[12:0];
        return {m[12], m[10:5], rs2[4:0], rs1[4:0], f3, m[4:1], m[11],
                7'b1100011};
    endfunction

    function automatic logic [31:0] j_t(int imm, int rd);
        logic [20:0] m;
        m = imm[20:0];
        return {m[20], m[10:1], m[11], m[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic put(input int a, input logic [31:0] w);
        mem[a / 4] = w;
    endtask

    initial begin
        areset    = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++)
            mem[i] = '0;
        mem[5]   = 32'hDEAD_BEEF;
        mem[133] = 32'h1111_1111;

        put(32'h100, i_t(5, 0, 3'b000, 1, OPI));
        put(32'h104, r_t(7'h00, 1, 1, 3'b000, 2));
        put(32'h108, s_t(8, 2, 0));
        put(32'h10C, i_t(8, 0, 3'b010, 3, LD));
        put(32'h110, s_t(12, 3, 0));
        put(32'h114, i_t(-1, 0, 3'b000, 1, OPI));
        put(32'h118, i_t(1, 0, 3'b000, 2, OPI));
        put(32'h11C, j_t(-252, 0));
        put(32'h020, b_t(16, 2, 1, 3'b100));
        put(32'h030, b_t(8, 2, 1, 3'b000));
        put(32'h034, b_t(12, 1, 1, 3'b000));
        put(32'h040, j_t(-8, 1));
        put(32'h038, s_t(16, 1, 0));
        put(32'h03C, j_t(36, 0));
        put(32'h060, s_t(20, 0, 0));
        put(32'h064, i_t(32'hF0, 0, 3'b000, 4, OPI));
        put(32'h068, i_t(32'h0F, 4, 3'b110, 5, OPI));
        put(32'h06C, i_t(32'h3C, 5, 3'b111, 6, OPI));
        put(32'h070, r_t(7'h20, 5, 6, 3'b000, 7));
        put(32'h074, r_t(7'h00, 7, 5, 3'b111, 8));
        put(32'h078, r_t(7'h00, 6, 4, 3'b110, 9));
        put(32'h07C, r_t(7'h00, 6, 7, 3'b010, 10));
        put(32'h080, i_t(-1, 6, 3'b010, 11, OPI));
        put(32'h084, s_t(32'h200, 7, 0));
        put(32'h088, s_t(32'h204, 8, 0));
        put(32'h08C, s_t(32'h208, 9, 0));
        put(32'h090, s_t(32'h20C, 10, 0));
        put(32'h094, s_t(32'h210, 11, 0));
        put(32'h098, i_t(32'h20B, 0, 3'b010, 12, LD));
        put(32'h09C, s_t(32'h216, 12, 0));
        put(32'h0A0, 32'hFFFF_FFFF);

        repeat (3) begin
            @(negedge clk);
            #2;
            chk(instr_retired, 1'b0, "reset retire");
            chk(mem_req, 1'b0, "reset req");
        end
        chk(mem_addr, 32'h0, "reset addr");
        chk(pc_out, 32'h100, "reset pc");
        chk(trap, 1'b0, "reset trap");

        @(posedge clk);
        #1 areset = 1'b0;
        txn_idx    = 0;
        fetch_wait = 5;
        repeat (2) @(negedge clk);
        #2;
        chk(mem_req, 1'b1, "first req");
        chk(mem_addr, 32'h100, "first addr");
        @(posedge clk);
        #1 areset = 1'b1;
        #1;
        chk(mem_req, 1'b0, "midreset req");
        chk(mem_addr, 32'h0, "midreset addr");
        repeat (2) @(posedge clk);
        #1 areset = 1'b0;

        step(32'h100, 0, 0, 4, "addi");
        step(32'h104, 0, 0, 4, "add");
        step(32'h108, 0, 2, 6, "sw");
        chk(st_addr, 32'h8, "sw addr");
        chk(st_data, 32'd10, "sw data");
        step(32'h10C, 0, 2, 7, "lw");
        step(32'h110, 1, 1, 6, "sw x3");
        chk(mem[3], 32'd10, "x3");
        step(32'h114, 0, 0, 4, "addi -1");
        step(32'h118, 0, 0, 4, "addi 1");
        step(32'h11C, 0, 0, 4, "jal x0");
        step(32'h020, 0, 0, 3, "blt");
        step(32'h030, 0, 0, 3, "beq nt");
        step(32'h034, 0, 0, 3, "beq t");
        step(32'h040, 0, 0, 4, "jal x1");
        step(32'h038, 0, 0, 4, "sw x1");
        chk(mem[4], 32'h44, "link");
        step(32'h03C, 0, 0, 4, "jal fwd");
        step(32'h060, 0, 0, 4, "sw x0");
        chk(mem[5], 32'h0, "x0");
        for (int a = 32'h64; a <= 32'h94; a += 4)
            step(a, 0, 0, 4, "alu/sw");
        step(32'h098, 0, 0, 5, "lw misal");
        step(32'h09C, 0, 0, 4, "sw misal");
        chk(st_addr, 32'h214, "misal addr");
        chk(mem[128], 32'hFFFF_FF3D, "sub");
        chk(mem[129], 32'h3D, "and");
        chk(mem[130], 32'hFC, "or");
        chk(mem[131], 32'h1, "slt");
        chk(mem[132], 32'h0, "slti");
        chk(mem[133], 32'hFC, "lw x12");

        fetch_wait = 0;
        txn_idx    = 0;
        lat        = 0;
        do begin
            @(negedge clk);
            #2;
            lat++;
        end while (!trap && lat < 20);
        chk(lat, 3, "trap lat");
        chk(fetch_addr, 32'hA0, "trap fetch");
        chk(pc_out, 32'hA4, "trap pc");
        r0 = req_cyc;
        repeat (10) @(negedge clk);
        #2;
        chk(req_cyc, r0, "trap no req");
        chk(trap, 1'b1, "trap sticky");
        chk(instr_retired, 1'b0, "trap retire");

        @(posedge clk);
        #1 areset = 1'b1;
        #1;
        chk(trap, 1'b0, "trap clear");
        chk(pc_out, 32'h100, "trap reset pc");
        @(posedge clk);
        #1 areset = 1'b0;
        step(32'h100, 0, 0, 4, "refetch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
